// File: rtl/fetch_aligner_pkg.sv
// rtl/fetch_aligner_pkg.sv - shared fetch FSM encodings, buffer sizing and compressed-instruction test
package fetch_aligner_pkg;

  localparam int FA_HW_SLOTS = 3;

  typedef enum logic [1:0] {
    FA_S_REQ  = 2'd0,
    FA_S_WAIT = 2'd1,
    FA_S_DROP = 2'd2
  } fa_state_e;

  // Also used by the expander: any low pair other than 2'b11 marks a 16-bit instruction.
  function automatic logic is_compressed(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/fa_halfword_buf.sv
// rtl/fa_halfword_buf.sv - three-slot halfword shift/append buffer with occupancy count
module fa_halfword_buf
  import fetch_aligner_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic [1:0]  shift_i,
  input  logic [1:0]  app_cnt_i,
  input  logic [31:0] app_data_i,
  output logic [15:0] slot0_o,
  output logic [15:0] slot1_o,
  output logic [1:0]  count_o
);

  localparam int BUF_W = FA_HW_SLOTS * 16;

  logic [BUF_W-1:0] data_q, data_d, shifted, keep, app_m;
  logic [1:0]       count_q, count_d, cnt_s;

  always_comb begin
    cnt_s   = count_q - shift_i;
    shifted = data_q >> {shift_i, 4'b0000};
    // Slots beyond the post-shift count are zeroed so appended halfwords can be OR-ed in.
    keep    = ~({BUF_W{1'b1}} << {cnt_s, 4'b0000});
    case (app_cnt_i)
      2'd1:    app_m = {{(BUF_W-16){1'b0}}, app_data_i[15:0]};
      2'd2:    app_m = {{(BUF_W-32){1'b0}}, app_data_i};
      default: app_m = '0;
    endcase
    data_d  = (shifted & keep) | (app_m << {cnt_s, 4'b0000});
    count_d = cnt_s + app_cnt_i;
    if (clear_i) begin
      data_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign slot0_o = data_q[15:0];
  assign slot1_o = data_q[31:16];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_aligner.sv
// rtl/fetch_aligner.sv - word fetch, halfword buffering and 16/32-bit instruction extraction
module fetch_aligner
  import fetch_aligner_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic            inst_is_c,
  output logic [XLEN-1:0] inst_pc
);

  localparam logic [XLEN-1:0] PC_STEP_C = XLEN'(2);
  localparam logic [XLEN-1:0] PC_STEP_W = XLEN'(4);

  fa_state_e       state_q;
  logic [XLEN-1:0] fetch_addr_q, buf_pc_q;
  logic            skip_low_q;

  logic [15:0] slot0, slot1;
  logic [1:0]  count;
  logic        slot0_c, req_fire, rsp_fill, inst_fire, pending;
  logic [1:0]  shift_amt, app_cnt;
  logic [31:0] app_data;
  logic        unused_redirect_bit0;

  assign unused_redirect_bit0 = redirect_pc[0];

  fa_halfword_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (redirect_valid),
    .shift_i    (shift_amt),
    .app_cnt_i  (app_cnt),
    .app_data_i (app_data),
    .slot0_o    (slot0),
    .slot1_o    (slot1),
    .count_o    (count)
  );

  assign slot0_c    = is_compressed(slot0[1:0]);
  assign inst_valid = ((count != 2'd0) && slot0_c) || (count >= 2'd2);
  assign inst_is_c  = (count != 2'd0) && slot0_c;
  assign inst_data  = (count == 2'd0) ? 32'h0 :
                      slot0_c         ? {16'h0, slot0} : {slot1, slot0};
  assign inst_pc    = buf_pc_q;

  // Issuing only at count <= 1 leaves room for a full word when it returns.
  assign imem_req_valid = (state_q == FA_S_REQ) && (count <= 2'd1);
  assign imem_req_addr  = fetch_addr_q;

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign rsp_fill  = (state_q == FA_S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign inst_fire = inst_valid && inst_ready && !redirect_valid;
  assign shift_amt = inst_fire ? (slot0_c ? 2'd1 : 2'd2) : 2'd0;
  assign app_cnt   = rsp_fill ? (skip_low_q ? 2'd1 : 2'd2) : 2'd0;
  assign app_data  = skip_low_q ? {16'h0, imem_rsp_data[31:16]} : imem_rsp_data;

  // A response still owed by memory after a redirect must be swallowed.
  assign pending = (((state_q == FA_S_WAIT) || (state_q == FA_S_DROP)) && !imem_rsp_valid)
                 || ((state_q == FA_S_REQ) && req_fire);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FA_S_REQ;
      fetch_addr_q <= {RESET_PC[XLEN-1:2], 2'b00};
      skip_low_q   <= RESET_PC[1];
      buf_pc_q     <= RESET_PC;
    end else if (redirect_valid) begin
      state_q      <= pending ? FA_S_DROP : FA_S_REQ;
      fetch_addr_q <= {redirect_pc[XLEN-1:2], 2'b00};
      skip_low_q   <= redirect_pc[1];
      buf_pc_q     <= {redirect_pc[XLEN-1:1], 1'b0};
    end else begin
      if (inst_fire) begin
        buf_pc_q <= buf_pc_q + (slot0_c ? PC_STEP_C : PC_STEP_W);
      end
      case (state_q)
        FA_S_REQ: begin
          if (req_fire) begin
            state_q      <= FA_S_WAIT;
            fetch_addr_q <= fetch_addr_q + PC_STEP_W;
          end
        end
        FA_S_WAIT: begin
          if (imem_rsp_valid) begin
            skip_low_q <= 1'b0;
            state_q    <= FA_S_REQ;
          end
        end
        FA_S_DROP: begin
          if (imem_rsp_valid) begin
            state_q <= FA_S_REQ;
          end
        end
        default: state_q <= FA_S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// tb/tb_fetch_aligner.sv - directed self-checking bench for fetch_aligner
module tb_fetch_aligner;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic        inst_is_c;
  logic [31:0] inst_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_aligner #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_is_c      (inst_is_c),
    .inst_pc        (inst_pc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [31:0] addr);
    check({tag, "_req_valid"}, {31'b0, imem_req_valid}, 32'h1);
    check({tag, "_req_addr"}, imem_req_addr, addr);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
  endtask

  task automatic rsp(input logic [31:0] data);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
  endtask

  task automatic consume();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] data, input logic c, input logic [31:0] pc);
    check({tag, "_valid"}, {31'b0, inst_valid}, 32'h1);
    check({tag, "_data"}, inst_data, data);
    check({tag, "_is_c"}, {31'b0, inst_is_c}, {31'b0, c});
    check({tag, "_pc"}, inst_pc, pc);
  endtask

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'h0;
    inst_ready = 1'b0;
    tick();
    tick();

    // reset state
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_is_c", {31'b0, inst_is_c}, 32'h0);
    check("rst_data", inst_data, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("rst_req_addr", imem_req_addr, 32'h0);
    rst = 1'b0;
    tick();

    // compressed instruction followed by a zero halfword
    issue("t1", 32'h0);
    rsp(32'h0000_4501);
    expect_inst("t1_c0", 32'h0000_4501, 1'b1, 32'h0);
    check("t1_req_hold", {31'b0, imem_req_valid}, 32'h0);
    consume();
    expect_inst("t1_c2", 32'h0000_0000, 1'b1, 32'h2);
    redirect(32'h0);

    // 32-bit instruction straddling words 0 and 4
    issue("t2a", 32'h0);
    rsp(32'h0513_4501);
    expect_inst("t2_c0", 32'h0000_4501, 1'b1, 32'h0);
    consume();
    check("t2_straddle_wait", {31'b0, inst_valid}, 32'h0);
    issue("t2b", 32'h4);
    check("t2_still_wait", {31'b0, inst_valid}, 32'h0);
    rsp(32'h0000_0000);
    expect_inst("t2_w2", 32'h0000_0513, 1'b0, 32'h2);
    consume();
    expect_inst("t2_c6", 32'h0000_0000, 1'b1, 32'h6);
    redirect(32'h0);

    // aligned 32-bit stream with decode always ready
    inst_ready = 1'b1;
    issue("t3a", 32'h0);
    rsp(32'h0050_0093);
    expect_inst("t3_w0", 32'h0050_0093, 1'b0, 32'h0);
    check("t3_req_hold", {31'b0, imem_req_valid}, 32'h0);
    tick();
    check("t3_empty", {31'b0, inst_valid}, 32'h0);
    issue("t3b", 32'h4);
    rsp(32'h0010_0113);
    expect_inst("t3_w4", 32'h0010_0113, 1'b0, 32'h4);
    tick();
    check("t3_pc8", inst_pc, 32'h8);
    inst_ready = 1'b0;

    // redirect while a fetch is outstanding
    issue("t4a", 32'h8);
    redirect(32'h0000_0102);
    check("t4_drop_req", {31'b0, imem_req_valid}, 32'h0);
    check("t4_drop_valid", {31'b0, inst_valid}, 32'h0);
    check("t4_drop_pc", inst_pc, 32'h102);
    rsp(32'hDEAD_BEEF);
    check("t4_dropped", {31'b0, inst_valid}, 32'h0);
    issue("t4b", 32'h100);
    rsp(32'h4505_FFFF);
    expect_inst("t4_c102", 32'h0000_4505, 1'b1, 32'h102);
    consume();
    check("t4_empty", {31'b0, inst_valid}, 32'h0);

    // backpressure with a full buffer
    issue("t5a", 32'h104);
    rsp(32'h4515_4511);
    expect_inst("t5_c104", 32'h0000_4511, 1'b1, 32'h104);
    consume();
    issue("t5b", 32'h108);
    rsp(32'h0050_0093);
    imem_req_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t5_no_req", {31'b0, imem_req_valid}, 32'h0);
      tick();
    end
    imem_req_ready = 1'b0;
    expect_inst("t5_c106", 32'h0000_4515, 1'b1, 32'h106);
    inst_ready = 1'b1;
    tick();
    expect_inst("t5_w108", 32'h0050_0093, 1'b0, 32'h108);
    tick();
    inst_ready = 1'b0;
    check("t5_empty", {31'b0, inst_valid}, 32'h0);
    check("t5_pc10c", inst_pc, 32'h10C);

    // asynchronous reset between clock edges during an outstanding fetch
    issue("t6a", 32'h10C);
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_pc", inst_pc, 32'h0);
    check("t6_async_req", {31'b0, imem_req_valid}, 32'h1);
    check("t6_async_addr", imem_req_addr, 32'h0);
    tick();
    rst = 1'b0;
    rsp(32'h1234_5678);
    check("t6_late_ignored", {31'b0, inst_valid}, 32'h0);
    issue("t6b", 32'h0);
    rsp(32'h0000_4501);
    expect_inst("t6_c0", 32'h0000_4501, 1'b1, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
